// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int unsigned IMEM_DATA_WIDTH = 32;
    localparam int unsigned RSP_CNT_WIDTH   = 16;

    // ADDI x0,x0,0 returned on faulting fetches
    localparam logic [IMEM_DATA_WIDTH-1:0] FILL_WORD_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic                       vld;
        logic                       err;
        logic [IMEM_DATA_WIDTH-1:0] data;
    } imem_rsp_t;

    // Byte-offset bits within one fetch word
    function automatic int unsigned ofs_of(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/imem_rsp_pipe.sv
// Fixed-latency response shift register; only valids (and the output stage) are reset.
module imem_rsp_pipe
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  imem_rsp_t req,
    output imem_rsp_t rsp
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("imem_rsp_pipe: LATENCY must be at least 1");
    end

    imem_rsp_t [LATENCY-1:0] stg;
    imem_rsp_t [LATENCY-1:0] feed;

    always_comb begin
        feed    = '0;
        feed[0] = req;
        for (int i = 1; i < LATENCY; i++) begin
            feed[i] = stg[i-1];
        end
    end

    // Last stage keeps data/err while idle so the outputs hold their last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg[i].vld <= 1'b0;
            end
            stg[LATENCY-1] <= '0;
        end else begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                stg[i] <= feed[i];
            end
            stg[LATENCY-1].vld <= feed[LATENCY-1].vld;
            if (feed[LATENCY-1].vld) begin
                stg[LATENCY-1].err  <= feed[LATENCY-1].err;
                stg[LATENCY-1].data <= feed[LATENCY-1].data;
            end
        end
    end

    assign rsp = stg[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: preloadable word array answering IFU fetches after LATENCY cycles.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD = DATA_WIDTH'(FILL_WORD_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ifu_req_addr_vld,
    input  logic [ADDR_WIDTH-1:0]    ifu_req_addr,
    output logic                     ifu_rsp_data_vld,
    output logic [DATA_WIDTH-1:0]    ifu_rsp_data,
    output logic                     ifu_rsp_err,
    input  logic                     load_vld,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data
);

    localparam int unsigned OFS = ofs_of(DATA_WIDTH);
    localparam int unsigned IDX = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("imem_responder: LATENCY must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("imem_responder: DEPTH must be a power of two");
    end
    if ((DATA_WIDTH < 8) || (DATA_WIDTH > IMEM_DATA_WIDTH) ||
        ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_width
        $error("imem_responder: DATA_WIDTH must be a power of two in 8..32");
    end
    if (OFS + IDX > ADDR_WIDTH) begin : g_bad_addr
        $error("imem_responder: OFS+IDX exceeds ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [IDX-1:0]           idx;
    logic                     misaligned;
    logic                     out_of_range;
    imem_rsp_t                req;
    imem_rsp_t                rsp;
    logic [RSP_CNT_WIDTH-1:0] rsp_cnt;

    assign idx          = ifu_req_addr[OFS +: IDX];
    assign misaligned   = (ifu_req_addr & OFS_MASK) != '0;
    assign out_of_range = (ifu_req_addr >> (OFS + IDX)) != '0;

    // Read happens at acceptance, so a same-cycle load is seen only by later fetches
    always_comb begin
        req      = '0;
        req.vld  = ifu_req_addr_vld;
        req.err  = misaligned | out_of_range;
        req.data = req.err ? IMEM_DATA_WIDTH'(FILL_WORD) : IMEM_DATA_WIDTH'(mem[idx]);
    end

    always_ff @(posedge clk) begin
        if (load_vld) begin
            mem[load_addr] <= load_data;
        end
    end

    imem_rsp_pipe #(
        .LATENCY (LATENCY)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .rsp   (rsp)
    );

    assign ifu_rsp_data_vld = rsp.vld;
    assign ifu_rsp_err      = rsp.err;
    assign ifu_rsp_data     = DATA_WIDTH'(rsp.data);

    // Saturating count of issued responses, debug visibility only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_cnt <= '0;
        end else if (ifu_rsp_data_vld && (rsp_cnt != {RSP_CNT_WIDTH{1'b1}})) begin
            rsp_cnt <= rsp_cnt + RSP_CNT_WIDTH'(1);
        end
    end

    a_cnt_sat: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_cnt == {RSP_CNT_WIDTH{1'b1}}) |=> (rsp_cnt == {RSP_CNT_WIDTH{1'b1}}));

endmodule
